// File: rtl/clk_div_gen.sv
// Multi-channel clock divider / enable generator: per-channel tick strobe and 50% divided level,
// with runtime ratio changes deferred to a terminal count so no short or long periods appear.
module clk_div_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk
);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] div_reg_q, div_reg_d;
  logic [NUM_CH-1:0][CNT_W-1:0] pend_div_q, pend_div_d;
  logic [NUM_CH-1:0]            pend_valid_q, pend_valid_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            div_clk_q, div_clk_d;
  logic [NUM_CH-1:0]            running, terminal, apply;
  logic                         wr_ok;

  // Writes to channels that do not exist are always accepted and then dropped.
  always_comb begin
    cfg_ready = 1'b1;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_valid_q[i];
      end
    end
  end

  assign wr_ok = cfg_valid & cfg_ready;

  always_comb begin
    cnt_d        = cnt_q;
    div_reg_d    = div_reg_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    tick_d       = '0;
    div_clk_d    = div_clk_q;
    running      = '0;
    terminal     = '0;
    apply        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      running[i]  = en[i] && (div_reg_q[i] != '0);
      terminal[i] = running[i] && (cnt_q[i] == div_reg_q[i] - CNT_W'(1));
      if (terminal[i]) begin
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b1;
        div_clk_d[i] = ~div_clk_q[i];
      end else if (running[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = '0;
      end
      // A pending ratio lands on a period boundary, or at once when the channel is idle.
      apply[i] = pend_valid_q[i] && (terminal[i] || !en[i] || (div_reg_q[i] == '0));
      if (apply[i]) begin
        div_reg_d[i]    = pend_div_q[i];
        cnt_d[i]        = '0;
        pend_valid_d[i] = 1'b0;
      end
      if (wr_ok && (cfg_ch == CH_W'(i))) begin
        pend_div_d[i]   = cfg_div;
        pend_valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        div_reg_q[i]  <= CNT_W'(DEFAULT_DIV);
        pend_div_q[i] <= '0;
      end
      pend_valid_q <= '0;
      tick_q       <= '0;
      div_clk_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      div_reg_q    <= div_reg_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      div_clk_q    <= div_clk_d;
    end
  end

  assign tick    = tick_q;
  assign div_clk = div_clk_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: reset/default table, then scenario sequences scored against an
// event-schedule model that tracks the edge of each channel's next tick.
module tb_clk_div_gen;

  localparam int NUM_CH = 2;
  localparam int DEF    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = 2'b00;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = 2'b00;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready;
  logic [1:0] tick;
  logic [1:0] div_clk;

  clk_div_gen #(
    .NUM_CH(NUM_CH), .CNT_W(8), .DEFAULT_DIV(DEF), .CH_W(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .tick(tick), .div_clk(div_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] en;
    logic [1:0] t;
    logic [1:0] c;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic [1:0] t;
    logic [1:0] c;
    string      tag;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Model state: absolute edge count, next tick edge, ratio, level, pending ratio.
  int         m_e = 0;
  int         m_nxt[2];
  int         m_per[2];
  int         m_pdiv[2];
  logic [1:0] m_lvl = 2'b00;
  logic [1:0] m_pend = 2'b00;

  function automatic logic ready_exp(input logic r, input logic [1:0] ch);
    if (r) return 1'b1;
    if (ch >= 2'(NUM_CH)) return 1'b1;
    return ~m_pend[ch];
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] e_in, input logic acc,
                            input logic [1:0] ch, input logic [7:0] d,
                            output logic [1:0] t_exp, output logic [1:0] c_exp);
    m_e++;
    t_exp = 2'b00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r) begin
        m_per[i]  = DEF;
        m_lvl[i]  = 1'b0;
        m_pend[i] = 1'b0;
        m_nxt[i]  = m_e + m_per[i];
      end else begin
        if (e_in[i] && m_per[i] != 0 && m_e == m_nxt[i]) begin
          t_exp[i] = 1'b1;
          m_lvl[i] = ~m_lvl[i];
          if (m_pend[i]) begin
            m_per[i]  = m_pdiv[i];
            m_pend[i] = 1'b0;
          end
          m_nxt[i] = m_e + m_per[i];
        end else if (!e_in[i] || m_per[i] == 0) begin
          if (m_pend[i]) begin
            m_per[i]  = m_pdiv[i];
            m_pend[i] = 1'b0;
          end
          m_nxt[i] = m_e + m_per[i];
        end
        if (acc && ch == 2'(i)) begin
          m_pend[i] = 1'b1;
          m_pdiv[i] = int'(d);
        end
      end
    end
    c_exp = m_lvl;
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] e_in, input logic v,
                               input logic [1:0] ch, input logic [7:0] d,
                               input bit use_tbl, input vec_t tv, input string tag,
                               output logic acc);
    logic       rdy_e;
    logic [1:0] mt, mc;
    exp_t       x;
    rst = r; en = e_in; cfg_valid = v; cfg_ch = ch; cfg_div = d;
    #1;
    rdy_e = use_tbl ? tv.rdy : ready_exp(r, ch);
    n_checks++;
    if (cfg_ready !== rdy_e) begin
      n_fail++;
      $display("[TB] FAIL %s_ready: got cfg_ready=%b, want %b (t=%0t)", tag, cfg_ready, rdy_e, $time);
    end
    acc = v && ready_exp(r, ch) && !r;
    model_edge(r, e_in, acc, ch, d, mt, mc);
    x.t = use_tbl ? tv.t : mt;
    x.c = use_tbl ? tv.c : mc;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t x;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got output with no expectation, want one queued");
      return;
    end
    x = sb.pop_front();
    if (tick !== x.t || div_clk !== x.c) begin
      n_fail++;
      $display("[TB] FAIL %s: got tick=%b div_clk=%b, want tick=%b div_clk=%b (t=%0t)",
               x.tag, tick, div_clk, x.t, x.c, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] e_in, input logic v,
                       input logic [1:0] ch, input logic [7:0] d, input string tag,
                       output logic acc);
    vec_t dummy;
    dummy = '{r: 1'b0, en: 2'b00, t: 2'b00, c: 2'b00, rdy: 1'b0};
    applyStimulus(r, e_in, v, ch, d, 1'b0, dummy, tag, acc);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic [1:0] e_in, input string tag);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, e_in, 1'b0, 2'd0, 8'd0, tag, acc);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got no finish by 50us, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic acc;
    int   tries;

    vecs[0]  = '{r: 1'b1, en: 2'b11, t: 2'b00, c: 2'b00, rdy: 1'b1};
    vecs[1]  = '{r: 1'b1, en: 2'b11, t: 2'b00, c: 2'b00, rdy: 1'b1};
    vecs[2]  = '{r: 1'b1, en: 2'b11, t: 2'b00, c: 2'b00, rdy: 1'b1};
    vecs[3]  = '{r: 1'b0, en: 2'b11, t: 2'b00, c: 2'b00, rdy: 1'b1};
    vecs[4]  = '{r: 1'b0, en: 2'b11, t: 2'b11, c: 2'b11, rdy: 1'b1};
    vecs[5]  = '{r: 1'b0, en: 2'b11, t: 2'b00, c: 2'b11, rdy: 1'b1};
    vecs[6]  = '{r: 1'b0, en: 2'b11, t: 2'b11, c: 2'b00, rdy: 1'b1};
    vecs[7]  = '{r: 1'b0, en: 2'b11, t: 2'b00, c: 2'b00, rdy: 1'b1};
    vecs[8]  = '{r: 1'b0, en: 2'b11, t: 2'b11, c: 2'b11, rdy: 1'b1};
    vecs[9]  = '{r: 1'b0, en: 2'b11, t: 2'b00, c: 2'b11, rdy: 1'b1};
    vecs[10] = '{r: 1'b0, en: 2'b11, t: 2'b11, c: 2'b00, rdy: 1'b1};

    // Reset and default-ratio behaviour from fixed vectors.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].r, vecs[i].en, 1'b0, 2'd0, 8'd0, 1'b1, vecs[i],
                    $sformatf("table%0d", i), acc);
      @(posedge clk);
      #1;
      checkOutput();
    end

    // Reprogram ch0 to 5 mid-period; ch1 keeps ratio 2.
    cycle(1'b0, 2'b11, 1'b1, 2'd0, 8'd5, "reprog_wr", acc);
    idle(16, 2'b11, "reprog_run");

    // Back-to-back writes to ch1: second stalls until the first applies.
    cycle(1'b0, 2'b11, 1'b1, 2'd1, 8'd3, "b2b_wr1", acc);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 20) begin
      cycle(1'b0, 2'b11, 1'b1, 2'd1, 8'd4, "b2b_wr2", acc);
      tries++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL b2b_accept: got no acceptance in 20 cycles, want acceptance");
    end
    idle(14, 2'b11, "b2b_run");

    // Edge ratios on ch0: D=1, then D=0, then D=3.
    cycle(1'b0, 2'b11, 1'b1, 2'd0, 8'd1, "d1_wr", acc);
    idle(8, 2'b11, "d1_run");
    cycle(1'b0, 2'b11, 1'b1, 2'd0, 8'd0, "d0_wr", acc);
    idle(6, 2'b11, "d0_run");
    cycle(1'b0, 2'b11, 1'b1, 2'd0, 8'd3, "d3_wr", acc);
    idle(9, 2'b11, "d3_run");

    // Drop en[0] for four cycles, then re-enable.
    idle(4, 2'b10, "en_low");
    idle(8, 2'b11, "en_back");

    // Writes to nonexistent channels are taken and ignored.
    cycle(1'b0, 2'b11, 1'b1, 2'd3, 8'd9, "bad_ch3", acc);
    cycle(1'b0, 2'b11, 1'b1, 2'd2, 8'd1, "bad_ch2", acc);
    idle(6, 2'b11, "bad_run");

    // Reset while ch0 holds a pending ratio of 7.
    cycle(1'b0, 2'b11, 1'b1, 2'd0, 8'd7, "rst_wr", acc);
    cycle(1'b1, 2'b11, 1'b0, 2'd0, 8'd0, "rst_mid", acc);
    cycle(1'b1, 2'b11, 1'b0, 2'd0, 8'd0, "rst_mid", acc);
    idle(10, 2'b11, "rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised multi-channel clock divider / enable generator for synthesisable RTL.
- Each channel takes a runtime-programmable divide ratio and produces two outputs: a one-cycle tick strobe and a 50%-duty divided clock-level signal.
- Sits next to the testbench clock source. It supplies slower enables (e.g. 100 MHz → lower rates) to downstream blocks without creating new clock domains.
- Ratio changes are glitch-free: they are applied only at a terminal count.

Parameters:
- NUM_CH, 2: number of independent divider channels (1..16).
- CNT_W, 8: width of the divide ratio and the per-channel counter. Maximum ratio is 2^CNT_W-1.
- DEFAULT_DIV, 2: ratio loaded into every channel at reset. Must satisfy 1..2^CNT_W-1.
- CH_W, $clog2(NUM_CH) (minimum 1): width of the channel select field.

Ports:
- clk, in, 1: single system clock, rising-edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, NUM_CH: per-channel run enable.
- cfg_valid, in, 1: configuration write request.
- cfg_ch, in, CH_W: target channel of the write.
- cfg_div, in, CNT_W: new divide ratio D.
- cfg_ready, out, 1: write can be accepted this cycle.
- tick, out, NUM_CH: registered one-cycle strobe per channel period D.
- div_clk, out, NUM_CH: registered level that toggles on every tick, giving period 2·D cycles.

Behaviour:
- Clocking and reset: all state updates on the rising edge of clk. rst is sampled synchronously, active-high, and overrides all other inputs.
- Reset values:
  - cnt=0, tick=0, div_clk=0 for every channel.
  - div_reg=DEFAULT_DIV, pend_valid=0, pend_div=0.
  - cfg_ready=1 during and after reset.
- Per-channel counting, when en[i]=1 and div_reg[i]≠0:
  - If cnt==div_reg-1: next cnt=0, tick<=1, div_clk<=~div_clk.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - Timing: with rst released before edge 1 and en high, tick is high after edges D, 2D, 3D…; div_clk toggles at those same edges.
- D=1: tick is constantly high and div_clk toggles every cycle (period 2 clk).
- D=0: channel is stopped. cnt is held at 0, tick=0, div_clk holds its value.
- en[i]=0: cnt<=0 and tick<=0; div_clk holds. On re-enable, counting restarts from 0, so the first tick comes D edges later.
- Configuration handshake:
  - cfg_ready is combinational: cfg_ready = ~pend_valid[cfg_ch], or 1 when cfg_ch ≥ NUM_CH.
  - A write is accepted when cfg_valid && cfg_ready. cfg_valid may be held with data stable until accepted.
  - Accepted write to a valid channel: pend_div<=cfg_div, pend_valid<=1.
  - Accepted write with cfg_ch ≥ NUM_CH: dropped silently, no state change.
- Applying a pending ratio, for each channel with pend_valid=1:
  - Apply at the edge where one of these holds: the channel hits its terminal count; en[i]=0; or div_reg[i]==0.
  - On apply: div_reg<=pend_div, cnt<=0, pend_valid<=0. The tick/div_clk update for that terminal count still occurs normally.
  - The new period therefore begins exactly at the old boundary, with no short or long pulse.
- Simultaneous write and apply on the same channel in the same cycle: cfg_ready is 0 (pend_valid still 1), so the write stalls one cycle. There is no overwrite race.
- Writes to different channels are independent and proceed in parallel.
- Reset mid-operation: pending writes are discarded and div_reg returns to DEFAULT_DIV. Outputs are 0 after the reset edge.
- Arithmetic: cnt is CNT_W-bit unsigned, with no wrap beyond div_reg-1. cnt never exceeds div_reg-1, because of the apply rule.

Test Plan:
- Reset default: NUM_CH=2, DEFAULT_DIV=2, en=2'b11, 10 ns clk, rst 3 cycles → tick pulses every 2nd edge; div_clk period 40 ns; both channels in phase; all outputs 0 during rst.
- Reprogram: ch0 D=2→5, written mid-period → change applies at the next ch0 terminal count; thereafter tick spacing is 5 cycles and div_clk period is 100 ns; no pulse shorter than 2 cycles; ch1 unaffected.
- Back-to-back writes: two writes to ch1 on consecutive cycles with cfg_valid held → cfg_ready=0 on the second until the first applies; second value takes effect one period later.
- Edge ratios:
  - D=1 → tick constantly 1, div_clk toggles each cycle.
  - D=0 → tick=0 and div_clk frozen.
  - Then D=3 → applies on the next edge; first tick 3 edges later.
- Enable and invalid channel:
  - Drop en[0] for 4 cycles → cnt cleared, div_clk held; first tick D edges after re-enable.
  - cfg_ch=3 with NUM_CH=2 → accepted (cfg_ready=1), no channel changes.
- Reset mid-operation: assert rst while ch0 has a pending D=7 → pending cleared; after release ch0 runs at DEFAULT_DIV=2.
